// File: rtl/key_debounce.sv
// Debounces an active-low push-button: SYNC_STAGES synchroniser feeding a 4-state filter FSM.
// keyflag strobes for one cycle, in the same cycle that keyvalue first shows the accepted level.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int SYNC_STAGES     = 2
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic key,
   output logic keyflag,
   output logic keyvalue
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_RELEASED,
      S_PRESS_WAIT,
      S_PRESSED,
      S_RELEASE_WAIT
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt;
   logic [CNT_W-1:0]       w_cnt_nxt;
   logic                   r_flag;
   logic                   r_value;
   logic                   w_flag_nxt;
   logic                   w_value_nxt;
   logic                   w_key_s;

   // Synchroniser resets to the released level so no spurious press is seen after reset.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], key};
      end
   end

   assign w_key_s = r_sync[SYNC_STAGES-1];

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= S_RELEASED;
         r_cnt   <= '0;
         r_flag  <= 1'b0;
         r_value <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_flag  <= w_flag_nxt;
         r_value <= w_value_nxt;
      end
   end

   // Any disagreement in a WAIT state drops back to the stable state; counts never accumulate.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_flag_nxt  = 1'b0;
      w_value_nxt = r_value;
      case (r_state)
         S_RELEASED: begin
            if (!w_key_s) begin
               w_state_nxt = S_PRESS_WAIT;
               w_cnt_nxt   = '0;
            end
         end
         S_PRESS_WAIT: begin
            if (w_key_s) begin
               w_state_nxt = S_RELEASED;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = S_PRESSED;
               w_cnt_nxt   = '0;
               w_value_nxt = 1'b0;
               w_flag_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_PRESSED: begin
            if (w_key_s) begin
               w_state_nxt = S_RELEASE_WAIT;
               w_cnt_nxt   = '0;
            end
         end
         S_RELEASE_WAIT: begin
            if (!w_key_s) begin
               w_state_nxt = S_PRESSED;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = S_RELEASED;
               w_cnt_nxt   = '0;
               w_value_nxt = 1'b1;
               w_flag_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_RELEASED;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign keyflag  = r_flag;
   assign keyvalue = r_value;

endmodule

// File: tb/tb_key_debounce.sv
// Randomised and directed bench for key_debounce; a run-length model predicts each flag,
// a monitor pops and checks every flag plus keyvalue stability between flags.
module tb_key_debounce;
   localparam int DEB  = 10;
   localparam int SYNC = 2;

   logic sys_clk;
   logic sys_rst_n;
   logic key;
   logic keyflag;
   logic keyvalue;

   key_debounce #(.DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)) dut (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .key      (key),
      .keyflag  (keyflag),
      .keyvalue (keyvalue)
   );

   typedef struct {
      int   cyc;
      logic val;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   flag_cnt = 0;
   int   last_flag_cyc = 0;

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   task automatic chk(input string nm, input int act, input int req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic chk_lat(input string nm, input int c0);
      int lat;
      lat = last_flag_cyc - c0;
      total++;
      if (lat < SYNC + DEB || lat > SYNC + DEB + 1) begin
         bad++;
         $display("FAIL %s: latency %0d cycles, expected %0d..%0d", nm, lat, SYNC + DEB, SYNC + DEB + 1);
      end
   endtask

   // Reference: the pin, delayed SYNC samples (reset-filled with 1), is accepted once it has
   // disagreed with the debounced level for DEB+1 consecutive samples (entry sample + DEB counted).
   initial begin : model
      logic mq[$];
      logic ks;
      logic deb;
      int   run;
      mq = '{};
      for (int i = 0; i < SYNC; i++) mq.push_back(1'b1);
      deb = 1'b1;
      run = 0;
      forever begin
         @(posedge sys_clk or negedge sys_rst_n);
         if (sys_clk) cyc++;
         if (!sys_rst_n) begin
            mq = '{};
            for (int i = 0; i < SYNC; i++) mq.push_back(1'b1);
            deb = 1'b1;
            run = 0;
            exp_q = '{};
         end else begin
            mq.push_back(key);
            ks = mq.pop_front();
            run = (ks != deb) ? run + 1 : 0;
            if (run == DEB + 1) begin
               deb = ~deb;
               run = 0;
               exp_q.push_back('{cyc: cyc, val: deb});
            end
         end
      end
   end

   initial begin : monitor
      logic last_val;
      exp_t e;
      last_val = 1'b1;
      forever begin
         @(posedge sys_clk);
         #1;
         if (!sys_rst_n) begin
            last_val = 1'b1;
            chk("reset_flag", int'(keyflag), 0);
            chk("reset_value", int'(keyvalue), 1);
         end else if (keyflag) begin
            flag_cnt++;
            last_flag_cyc = cyc;
            if (exp_q.size() == 0) begin
               chk("unexpected_flag", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("flag_cycle", cyc, e.cyc);
               chk("flag_value", int'(keyvalue), int'(e.val));
               last_val = e.val;
            end
         end else begin
            chk("value_stable", int'(keyvalue), int'(last_val));
         end
      end
   end

   task automatic hold(input logic v, input int n);
      key = v;
      repeat (n) @(negedge sys_clk);
   endtask

   initial begin : stim
      int c0;
      int f0;
      logic lvl;
      sys_rst_n = 1'b0;
      key       = 1'b0;
      @(negedge sys_clk);

      // 1: reset held with key pressed, then released with key idle
      repeat (5) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      hold(1'b1, 50);
      chk("idle_no_flag", flag_cnt, 0);

      // 2: clean press then clean release
      f0 = flag_cnt; c0 = cyc;
      hold(1'b0, 30);
      chk("press_flags", flag_cnt - f0, 1);
      chk_lat("press_latency", c0);
      chk("press_value", int'(keyvalue), 0);
      f0 = flag_cnt; c0 = cyc;
      hold(1'b1, 30);
      chk("release_flags", flag_cnt - f0, 1);
      chk_lat("release_latency", c0);
      chk("release_value", int'(keyvalue), 1);

      // 3: bounces of 3, 5, 9 cycles then settle low
      f0 = flag_cnt;
      hold(1'b0, 3); hold(1'b1, 3);
      hold(1'b0, 5); hold(1'b1, 5);
      hold(1'b0, 9); hold(1'b1, 9);
      chk("bounce_no_flag", flag_cnt - f0, 0);
      c0 = cyc;
      hold(1'b0, 30);
      chk("bounce_flags", flag_cnt - f0, 1);
      chk_lat("bounce_latency", c0);

      // 4: boundary; the entry sample precedes DEB counted samples
      hold(1'b1, 30);
      f0 = flag_cnt;
      hold(1'b0, DEB);
      hold(1'b1, 20);
      chk("short_no_flag", flag_cnt - f0, 0);
      chk("short_value", int'(keyvalue), 1);
      hold(1'b0, DEB + 1);
      hold(1'b1, 3);
      hold(1'b0, 20);
      chk("exact_flags", flag_cnt - f0, 1);
      chk("exact_value", int'(keyvalue), 0);

      // 5: reset in the middle of a press filter
      hold(1'b1, 30);
      f0 = flag_cnt;
      hold(1'b0, SYNC + 1 + 6);
      sys_rst_n = 1'b0;
      #1;
      chk("midrst_flag", int'(keyflag), 0);
      chk("midrst_value", int'(keyvalue), 1);
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      c0 = cyc;
      hold(1'b0, 30);
      chk("midrst_flags", flag_cnt - f0, 1);
      chk_lat("midrst_latency", c0);

      // 6: long hold gives a single flag
      hold(1'b1, 30);
      f0 = flag_cnt;
      hold(1'b0, 1000);
      chk("long_flags", flag_cnt - f0, 1);
      chk("long_value", int'(keyvalue), 0);

      // random bouncing, every flag checked by the monitor against the model
      for (int i = 0; i < 60; i++) begin
         lvl = 1'($urandom_range(0, 1));
         hold(lvl, int'($urandom_range(1, 25)));
      end
      hold(lvl, 40);
      chk("pending_flags", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
